la_clkgate_ctrl: RTL and testbench
==================================

// Module: la_clkgate_ctrl
// PURPOSE
//  Idle-driven clock-gating controller that sequences an integrated "and" clock gate (la_clkicgand).
//  Runs on the free-running clk and watches a domain busy flag and a wake request.
//  Drops en to the ICG after a programmable idle run, and restores it on demand.
//  Reports clock availability to requesters with a req/ack handshake.
// PARAMETERS
//  IDLE_CNT  16  consecutive idle cycles before gating; legal range 1..2**16-1
//  WAKE_CNT  2   cycles from en re-assert to wake_ack; covers ICG latch and tree settle; legal >=1
//  SW        16  width of gated-cycle statistics counter
// PORTS
//  clk        in   1   free-running clock (same clock as the ICG clk input)
//  reset      in   1   asynchronous, active-high reset
//  busy       in   1   gated domain has work in flight; blocks gating and wakes
//  wake_req   in   1   level request for a running clock; held until wake_ack
//  bypass     in   1   force clock on; overrides idle gating
//  te         in   1   scan test enable; passed through to the ICG te
//  en         out  1   registered enable to ICG en input
//  icg_te     out  1   combinational copy of te
//  wake_ack   out  1   1 = gated clock guaranteed running
//  gated      out  1   1 = controller in GATED state
//  stat_cnt   out  SW  gated-cycle count (see CONFIGURATION)
//  stat_clr   in   1   synchronous clear of stat_cnt
// BEHAVIOUR
//  Reset (async): state=RUN, en=1, wake_ack=1, gated=0, idle/wake counters=0, stat_cnt=0.
//  Clock runs out of reset so gated-domain resets propagate.
//  en, wake_ack and gated are flop outputs (no glitches into the ICG latch); icg_te=te.
//  idle = ~busy & ~wake_req & ~bypass.
//  RUN: en=1, wake_ack=1.
//   - idle cnt +1 each idle cycle; cleared to 0 on any non-idle cycle.
//   - Edge sampling the IDLE_CNT-th consecutive idle cycle -> GATED; en=0, wake_ack=0, gated=1.
//  GATED: en=0.
//   - On edge sampling busy|wake_req|bypass -> WAKE; en=1, wake_ack stays 0, wake cnt=0.
//  WAKE: en=1; wake cnt +1 per cycle.
//   - When wake cnt==WAKE_CNT-1 -> RUN; wake_ack=1.
//   - wake_ack therefore rises WAKE_CNT edges after the wake edge.
//   - wake_req/busy changes in WAKE are ignored; WAKE always completes.
//   - bypass=1 in WAKE also waits for completion.
//  Simultaneous events:
//   - busy or wake_req high on the threshold edge: stay in RUN, counter clears.
//   - Wake and gate conditions never coincide, because GATED only exits.
//  Idle counter saturates at IDLE_CNT-1, so there is no wrap-around.
//   - Width is $clog2(IDLE_CNT+1).
//  Handshake:
//   - wake_req may drop after wake_ack is seen.
//   - Dropping wake_req before ack does not abort the wake.
//  Reset asserted mid-operation: immediate return to reset values with en=1.
//  te=1 does not change the FSM; the ICG itself forces eclk on.
// CONFIGURATION
//  Macro LA_CLKGATE_STATS_EN:
//   defined: stat_cnt counts clk cycles with en=0 and saturates at 2**SW-1.
//            stat_clr=1 zeroes it next edge; clear wins over increment.
//   undefined: stat_cnt tied to 0, stat_clr ignored, no counter flops; ports still present.
// TESTING
//  1 Reset: reset=1 async mid-cycle -> en=1, wake_ack=1, gated=0 immediately; stat_cnt=0.
//  2 Gate: IDLE_CNT=4, busy 1->0 sampled low at edges 1..4 -> en=0, gated=1 after edge 4, not edge 3.
//  3 Near-miss: busy low 3 cycles, high at edge 4 -> en stays 1; next idle run restarts from 0.
//  4 Wake: GATED, WAKE_CNT=2, wake_req high at edge k -> en=1 after k; wake_ack=1 after k+2;
//    drop wake_req at k+1 -> ack still after k+2.
//  5 Bypass: bypass=1 in GATED -> WAKE then RUN; held bypass keeps en=1 for 100 idle cycles.
//  6 Stats (macro on, SW=4): gated 20 cycles -> stat_cnt=15 saturated;
//    stat_clr with en=0 -> 0 then counts again; macro off -> stat_cnt=0 throughout.

Source files
------------

// File: rtl/la_clkgate_ctrl.sv
// Idle-driven clock-gating controller sequencing an AND-type ICG, with req/ack wake handshake.
// Optional gated-cycle statistics counter enabled by defining LA_CLKGATE_STATS_EN.
module la_clkgate_ctrl #(
    parameter int unsigned IDLE_CNT = 16,
    parameter int unsigned WAKE_CNT = 2,
    parameter int unsigned SW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          busy,
    input  logic          wake_req,
    input  logic          bypass,
    input  logic          te,
    output logic          en,
    output logic          icg_te,
    output logic          wake_ack,
    output logic          gated,
    output logic [SW-1:0] stat_cnt,
    input  logic          stat_clr
);

    localparam int unsigned IW = $clog2(IDLE_CNT + 1);
    localparam int unsigned WW = (WAKE_CNT > 1) ? $clog2(WAKE_CNT) : 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        GATED = 2'd1,
        WAKE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idle_cnt, idle_cnt_nxt;
    logic [WW-1:0] wake_cnt, wake_cnt_nxt;
    logic          en_nxt, wake_ack_nxt, gated_nxt;
    logic          idle;

    assign idle   = ~busy & ~wake_req & ~bypass;
    assign icg_te = te;

    // en/wake_ack/gated are registered so the ICG latch never sees a glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            idle_cnt <= '0;
            wake_cnt <= '0;
            en       <= 1'b1;
            wake_ack <= 1'b1;
            gated    <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
            wake_cnt <= wake_cnt_nxt;
            en       <= en_nxt;
            wake_ack <= wake_ack_nxt;
            gated    <= gated_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = '0;
        wake_cnt_nxt = '0;
        en_nxt       = 1'b1;
        wake_ack_nxt = 1'b1;
        gated_nxt    = 1'b0;
        unique case (state)
            RUN: begin
                if (idle) begin
                    if (idle_cnt == IW'(IDLE_CNT - 1)) begin
                        state_nxt    = GATED;
                        en_nxt       = 1'b0;
                        wake_ack_nxt = 1'b0;
                        gated_nxt    = 1'b1;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                end
            end
            GATED: begin
                if (!idle) begin
                    state_nxt    = WAKE;
                    wake_ack_nxt = 1'b0;
                end else begin
                    en_nxt       = 1'b0;
                    wake_ack_nxt = 1'b0;
                    gated_nxt    = 1'b1;
                end
            end
            WAKE: begin
                // Inputs are ignored here: a started wake always runs to completion.
                if (wake_cnt == WW'(WAKE_CNT - 1)) begin
                    state_nxt = RUN;
                end else begin
                    wake_cnt_nxt = wake_cnt + 1'b1;
                    wake_ack_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

`ifdef LA_CLKGATE_STATS_EN
    logic [SW-1:0] stat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
        end else if (stat_clr) begin
            stat_q <= '0;
        end else if (!en && (stat_q != '1)) begin
            stat_q <= stat_q + 1'b1;
        end
    end

    assign stat_cnt = stat_q;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_la_clkgate_ctrl.sv
// Directed self-checking bench for la_clkgate_ctrl (IDLE_CNT=4, WAKE_CNT=2, SW=4).
module tb_la_clkgate_ctrl;

    logic       clk = 1'b0;
    logic       reset, busy, wake_req, bypass, te, stat_clr;
    logic       en, icg_te, wake_ack, gated;
    logic [3:0] stat_cnt;
    int         checks = 0;
    int         failures = 0;
    logic       en_dropped;

    la_clkgate_ctrl #(.IDLE_CNT(4), .WAKE_CNT(2), .SW(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .wake_req (wake_req),
        .bypass   (bypass),
        .te       (te),
        .en       (en),
        .icg_te   (icg_te),
        .wake_ack (wake_ack),
        .gated    (gated),
        .stat_cnt (stat_cnt),
        .stat_clr (stat_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] stat_exp(input int unsigned v);
`ifdef LA_CLKGATE_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    initial begin
        reset = 1'b1; busy = 1'b1; wake_req = 1'b0; bypass = 1'b0; te = 1'b0; stat_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_en", en, 1); check("rst_ack", wake_ack, 1);
        check("rst_gated", gated, 0); check("rst_stat", stat_cnt, 0);

        // Gate after exactly 4 idle edges
        tick();
        busy = 1'b0;
        tick(); tick(); tick();
        check("gate_e3_en", en, 1); check("gate_e3_gated", gated, 0);
        tick();
        check("gate_e4_en", en, 0); check("gate_e4_gated", gated, 1);
        check("gate_e4_ack", wake_ack, 0);

        // Wake via wake_req, dropped before ack
        wake_req = 1'b1;
        tick();
        check("wake_k_en", en, 1); check("wake_k_ack", wake_ack, 0);
        check("wake_k_gated", gated, 0);
        wake_req = 1'b0;
        tick();
        check("wake_k1_ack", wake_ack, 0); check("wake_k1_en", en, 1);
        tick();
        check("wake_k2_ack", wake_ack, 1);

        // Near-miss: busy on the 4th edge restarts the run
        tick(); tick(); tick();
        busy = 1'b1;
        tick();
        check("near_en", en, 1);
        busy = 1'b0;
        tick(); tick(); tick();
        check("near_restart_en", en, 1); check("near_restart_gated", gated, 0);
        tick();
        check("near_gate", gated, 1);

        // te passes through and leaves the FSM alone
        te = 1'b1;
        #1 check("icg_te_hi", icg_te, 1);
        tick();
        check("te_gated", gated, 1); check("te_en", en, 0);
        te = 1'b0;
        #1 check("icg_te_lo", icg_te, 0);

        // Bypass wakes and then holds the clock on
        bypass = 1'b1;
        tick();
        check("byp_en", en, 1); check("byp_ack0", wake_ack, 0);
        tick(); tick();
        check("byp_ack", wake_ack, 1); check("byp_gated", gated, 0);
        en_dropped = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (en !== 1'b1) en_dropped = 1'b1;
        end
        check("byp_hold_en_dropped", en_dropped, 0);
        bypass = 1'b0;

        // Statistics: clear wins, counts, saturates at 15
        tick(); tick(); tick(); tick();
        check("stat_gate", gated, 1);
        stat_clr = 1'b1;
        tick();
        check("stat_clr0", stat_cnt, 0);
        stat_clr = 1'b0;
        tick();
        check("stat_1", stat_cnt, stat_exp(1));
        tick();
        check("stat_2", stat_cnt, stat_exp(2));
        repeat (18) tick();
        check("stat_sat", stat_cnt, stat_exp(15));
        stat_clr = 1'b1;
        tick();
        check("stat_clr1", stat_cnt, 0);
        stat_clr = 1'b0;
        tick();
        check("stat_again", stat_cnt, stat_exp(1));

        // Busy wakes from GATED too
        busy = 1'b1;
        tick();
        check("busy_wake_en", en, 1);
        busy = 1'b0;
        tick(); tick();
        check("busy_wake_ack", wake_ack, 1);
        tick(); tick(); tick(); tick();
        check("regate", gated, 1);

        // Async reset mid-cycle while gated
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_en", en, 1); check("arst_ack", wake_ack, 1);
        check("arst_gated", gated, 0); check("arst_stat", stat_cnt, 0);
        tick();
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
